// File: rtl/pixel_sensor.sv
// pixel_sensor: one imaging pixel with a single-slope converter.
// Charge is integrated with saturation. During a conversion the controller drives a
// digital ramp on the shared bus, and the first ramp value that reaches the charge is
// latched as the result. During a read the pixel drives that result back on the same bus.
//
// Bus handshake (pixData): no valid/ready pair. Ownership follows the control inputs.
//   - While convert is high, the controller owns the bus.
//   - The pixel drives the bus only when its registered state is READ, read is high,
//     and none of erase/expose/convert is high.
//   - In every other case the pixel releases the bus to high impedance.
module pixel_sensor #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          erase,
    input  logic          expose,
    input  logic          convert,
    input  logic          read,
    input  logic [DW-1:0] light,
    inout  wire  [DW-1:0] pixData,
    output logic          latched,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERASE   = 3'd1,
        S_EXPOSE  = 3'd2,
        S_CONVERT = 3'd3,
        S_READ    = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_charge;
    logic [DW-1:0] r_value;
    logic          r_latched;
    logic          r_err;

    logic [DW:0]   w_sum;
    logic [DW-1:0] w_sat;
    logic [2:0]    w_nctl;
    logic          w_multi;
    logic          w_eff_latched;
    logic          w_trip;
    logic          w_drive;
    logic [DW-1:0] w_bus_out;

    // Pick the operation for this edge: erase > expose > convert > read, else idle
    always_comb begin
        w_next = S_IDLE;
        if (erase)        w_next = S_ERASE;
        else if (expose)  w_next = S_EXPOSE;
        else if (convert) w_next = S_CONVERT;
        else if (read)    w_next = S_READ;
    end

    // More than one control high in the same cycle is a protocol error
    assign w_nctl  = 3'(erase) + 3'(expose) + 3'(convert) + 3'(read);
    assign w_multi = (w_nctl > 3'd1);

    // Integrate at one extra bit so overflow saturates instead of wrapping
    assign w_sum = {1'b0, r_charge} + {1'b0, light};
    assign w_sat = w_sum[DW] ? {DW{1'b1}} : w_sum[DW-1:0];

    // A convert cycle that follows any non-convert cycle starts a fresh conversion
    assign w_eff_latched = (r_state == S_CONVERT) ? r_latched : 1'b0;
    assign w_trip        = !w_eff_latched && (pixData >= r_charge);

    // Drive only when the previous edge chose READ, read is still requested, and no other
    // control could make the controller drive the bus at the same time
    assign w_drive   = (r_state == S_READ) && read && !(convert || expose || erase);
    assign w_bus_out = r_latched ? r_value : {DW{1'b1}};
    assign pixData   = w_drive ? w_bus_out : {DW{1'bz}};

    // State, charge, result and flags; reset clears everything immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_charge  <= '0;
            r_value   <= '0;
            r_latched <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_multi) r_err <= 1'b1;
            case (w_next)
                S_ERASE: begin
                    r_charge  <= '0;
                    r_value   <= '0;
                    r_latched <= 1'b0;
                end
                S_EXPOSE: begin
                    r_charge <= w_sat;
                end
                S_CONVERT: begin
                    if (w_trip) begin
                        r_value   <= pixData;
                        r_latched <= 1'b1;
                    end else begin
                        r_latched <= w_eff_latched;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign latched = r_latched;
    assign err     = r_err;

endmodule
